// File: rtl/mem_arb_pkg.sv
// Shared encodings and counter widths for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int STREAK_W  = 4;
    localparam int TIMEOUT_W = 8;

    function automatic owner_t owner_of(input arb_state_t s);
        return (s == ST_BUSY_D) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-period watchdog: counts busy cycles without acknowledge and flags
// expiry once the count reaches TIMEOUT.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

    logic [TIMEOUT_W-1:0] count;

    // Saturates at LIMIT so expire stays asserted until the FSM leaves busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start || clear) begin
            count <= '0;
        end else if (run && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and the
// memory-stage data path (D), with a starvation guard and timeout watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_i,
    output logic        stall_d,
    output logic        bus_error,
    output logic        spurious_ack
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t           state;
    arb_state_t           state_next;
    owner_t               owner;
    logic                 grant_i;
    logic                 grant_d;
    logic                 busy;
    logic                 expire;
    logic                 finish;
    logic                 timed_out;
    logic [31:0]          done_rdata;
    logic [STREAK_W-1:0]  streak;

    assign busy      = (state != ST_IDLE);
    assign owner     = owner_of(state);
    assign finish    = busy & (mem_ack | expire);
    assign timed_out = busy & expire & ~mem_ack;

    // D normally wins a tie; once it has won MAX_D_STREAK times in a row
    // while I waited, I is forced through.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_req && !(i_req && (streak == STREAK_MAX))) begin
                    grant_d    = 1'b1;
                    state_next = ST_BUSY_D;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ack || expire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_we    <= d_we;
            mem_byte  <= d_byte;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_i) begin
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (!busy && !i_req) begin
            streak <= '0;
        end else if (grant_d && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_error    <= 1'b0;
            spurious_ack <= 1'b0;
        end else begin
            if (timed_out) begin
                bus_error <= 1'b1;
            end
            if (!busy && mem_ack) begin
                spurious_ack <= 1'b1;
            end
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (grant_i | grant_d),
        .clear   (finish),
        .run     (busy & ~mem_ack),
        .expire  (expire)
    );

    // A timed-out access completes with zero data.
    assign done_rdata = mem_ack ? mem_rdata : 32'd0;

    assign mem_req = busy;
    assign i_done  = finish & (owner == OWN_I);
    assign d_done  = finish & (owner == OWN_D);
    assign i_rdata = i_done ? done_rdata : 32'd0;
    assign d_rdata = d_done ? done_rdata : 32'd0;
    assign stall_i = i_req & ~i_done;
    assign stall_d = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter, compared each cycle
// against a transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int MAX_D_STREAK = 4;
    localparam int TIMEOUT      = 8;

    logic        clock;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_i;
    logic        stall_d;
    logic        bus_error;
    logic        spurious_ack;

    mem_port_arbiter #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_done       (i_done),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_byte       (d_byte),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_byte     (mem_byte),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall_i      (stall_i),
        .stall_d      (stall_d),
        .bus_error    (bus_error),
        .spurious_ack (spurious_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: who owns the memory (0 none, 1 I, 2 D), how long it
    // has waited, the D-win streak and the values latched at grant.
    int          m_owner, m_age, m_lat, m_streak;
    bit          m_noack, m_bus_err, m_spur;
    logic        m_we, m_byte;
    logic [31:0] m_addr, m_wdata;

    // Environment knobs and requester bookkeeping.
    bit          auto_i, auto_d, noack_all, rand_noack, force_spur, fixed_rd_en;
    int          i_rate, d_rate, spur_rate, lat_lo, lat_hi;
    logic [31:0] fixed_rd;
    bit          i_fin, d_fin, want_i, want_d;
    logic [31:0] want_i_addr, want_d_addr, want_d_wdata;
    logic        want_d_we;

    // Observations of the DUT used by the scenario-level checks.
    int          run_len, last_done_run, n_i_done, n_d_done;
    int          done_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic newIReq(input logic [31:0] a);
        i_req  = 1'b1;
        i_addr = a;
    endtask

    task automatic newDReq(input logic we, input logic by,
                           input logic [31:0] a, input logic [31:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_byte  = by;
        d_addr  = a;
        d_wdata = wd;
    endtask

    task automatic modelReset();
        m_owner   = 0;
        m_age     = 0;
        m_lat     = 0;
        m_streak  = 0;
        m_noack   = 1'b0;
        m_bus_err = 1'b0;
        m_spur    = 1'b0;
        m_we      = 1'b0;
        m_byte    = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        i_fin     = 1'b0;
        d_fin     = 1'b0;
        run_len   = 0;
    endtask

    // Compare every output with the model, then advance the model one clock.
    task automatic modelStep();
        bit          fin, fin_i, fin_d, tie_to_i;
        logic [31:0] rd;
        fin   = (m_owner != 0) && (mem_ack || (m_age == TIMEOUT));
        fin_i = fin && (m_owner == 1);
        fin_d = fin && (m_owner == 2);
        rd    = mem_ack ? mem_rdata : 32'd0;
        checkOutput("mem_req",      32'(mem_req),      32'(m_owner != 0));
        checkOutput("mem_we",       32'(mem_we),       32'(m_we));
        checkOutput("mem_byte",     32'(mem_byte),     32'(m_byte));
        checkOutput("mem_addr",     mem_addr,          m_addr);
        checkOutput("mem_wdata",    mem_wdata,         m_wdata);
        checkOutput("i_done",       32'(i_done),       32'(fin_i));
        checkOutput("d_done",       32'(d_done),       32'(fin_d));
        checkOutput("i_rdata",      i_rdata,           fin_i ? rd : 32'd0);
        checkOutput("d_rdata",      d_rdata,           fin_d ? rd : 32'd0);
        checkOutput("stall_i",      32'(stall_i),      32'(i_req && !fin_i));
        checkOutput("stall_d",      32'(stall_d),      32'(d_req && !fin_d));
        checkOutput("bus_error",    32'(bus_error),    32'(m_bus_err));
        checkOutput("spurious_ack", 32'(spurious_ack), 32'(m_spur));

        if (mem_req) run_len++;
        if (i_done || d_done) begin
            last_done_run = run_len;
            run_len = 0;
            done_q.push_back(i_done ? 1 : 2);
            if (i_done) n_i_done++;
            if (d_done) n_d_done++;
        end
        if (!mem_req) run_len = 0;

        i_fin = fin_i;
        d_fin = fin_d;
        if (m_owner != 0) begin
            if (fin) begin
                if (!mem_ack) m_bus_err = 1'b1;
                m_owner = 0;
            end else begin
                m_age++;
            end
        end else begin
            if (mem_ack) m_spur = 1'b1;
            tie_to_i = (m_streak == MAX_D_STREAK);
            if (d_req && !(i_req && tie_to_i)) begin
                m_owner = 2;
                m_we = d_we; m_byte = d_byte; m_addr = d_addr; m_wdata = d_wdata;
                m_streak = i_req ? m_streak + 1 : 0;
            end else if (i_req) begin
                m_owner = 1;
                m_we = 1'b0; m_byte = 1'b0; m_addr = i_addr; m_wdata = 32'd0;
                m_streak = 0;
            end else begin
                m_streak = 0;
            end
            if (m_owner != 0) begin
                m_age   = 0;
                m_lat   = int'($urandom_range(lat_hi, lat_lo));
                m_noack = noack_all || (rand_noack && ($urandom_range(19) == 0));
            end
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (i_fin) begin
                i_req = 1'b0;
                if (auto_i && pct(i_rate)) newIReq($urandom());
            end else if (!i_req && auto_i && pct(i_rate)) begin
                newIReq($urandom());
            end
            if (d_fin) begin
                d_req = 1'b0;
                if (auto_d && pct(d_rate))
                    newDReq(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom(), $urandom());
            end else if (!d_req && auto_d && pct(d_rate)) begin
                newDReq(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom(), $urandom());
            end
            if (want_i) begin
                want_i = 1'b0;
                newIReq(want_i_addr);
            end
            if (want_d) begin
                want_d = 1'b0;
                newDReq(want_d_we, 1'b0, want_d_addr, want_d_wdata);
            end
            mem_rdata = fixed_rd_en ? fixed_rd : $urandom();
            if (m_owner != 0) begin
                mem_ack = !m_noack && (m_age >= m_lat);
            end else begin
                mem_ack = force_spur || ((spur_rate != 0) && pct(spur_rate));
                force_spur = 1'b0;
            end
            #1;
            modelStep();
        end
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible.
    task automatic doReset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        mem_ack = 1'b0;
        #1;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_d_done",  32'(d_done),  32'd0);
        checkOutput("rst_i_done",  32'(i_done),  32'd0);
        modelReset();
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("rst_bus_error", 32'(bus_error),    32'd0);
        checkOutput("rst_spurious",  32'(spurious_ack), 32'd0);
        checkOutput("rst_mem_addr",  mem_addr,          32'd0);
        checkOutput("rst_mem_we",    32'(mem_we),       32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        auto_i = 0; auto_d = 0; noack_all = 0; rand_noack = 0; force_spur = 0;
        fixed_rd_en = 0; fixed_rd = '0;
        i_rate = 0; d_rate = 0; spur_rate = 0; lat_lo = 0; lat_hi = 0;
        want_i = 0; want_d = 0; want_i_addr = '0; want_d_addr = '0;
        want_d_wdata = '0; want_d_we = 1'b0;
        last_done_run = 0; n_i_done = 0; n_d_done = 0;
        modelReset();
        doReset();

        $display("[TB] single instruction fetch");
        fixed_rd_en = 1; fixed_rd = 32'h2008000A;
        want_i = 1; want_i_addr = 32'h00400000;
        applyStimulus(5);
        checkOutput("fetch_done_count", 32'(n_i_done), 32'd1);
        fixed_rd_en = 0;

        $display("[TB] simultaneous I and D");
        done_q.delete(); n_i_done = 0; n_d_done = 0;
        want_i = 1; want_i_addr = 32'h00400004;
        want_d = 1; want_d_we = 1'b1; want_d_addr = 32'h10010004; want_d_wdata = 32'hDEADBEEF;
        applyStimulus(6);
        checkOutput("tie_i_count", 32'(n_i_done), 32'd1);
        checkOutput("tie_d_count", 32'(n_d_done), 32'd1);
        checkOutput("tie_first_owner", (done_q.size() > 0) ? 32'(done_q[0]) : 32'd0, 32'd2);

        $display("[TB] starvation guard");
        doReset();
        done_q.delete();
        auto_i = 1; auto_d = 1; i_rate = 100; d_rate = 100;
        want_i = 1; want_i_addr = $urandom();
        want_d = 1; want_d_we = 1'b0; want_d_addr = $urandom(); want_d_wdata = $urandom();
        applyStimulus(24);
        begin
            int pattern[6] = '{2, 2, 2, 2, 1, 2};
            checkOutput("streak_len_ok", 32'(done_q.size() >= 6), 32'd1);
            for (int k = 0; k < 6 && k < done_q.size(); k++)
                checkOutput($sformatf("streak_order_%0d", k), 32'(done_q[k]), 32'(pattern[k]));
        end
        auto_i = 0; auto_d = 0;

        $display("[TB] timeout watchdog");
        doReset();
        n_d_done = 0;
        noack_all = 1;
        want_d = 1; want_d_we = 1'b0; want_d_addr = 32'h10010040; want_d_wdata = '0;
        applyStimulus(13);
        checkOutput("timeout_busy_cycles", 32'(last_done_run), 32'(TIMEOUT + 1));
        checkOutput("timeout_done_count",  32'(n_d_done), 32'd1);
        checkOutput("timeout_bus_error",   32'(bus_error), 32'd1);
        noack_all = 0; lat_lo = 1; lat_hi = 1;
        want_d = 1; want_d_we = 1'b1; want_d_addr = 32'h10010044; want_d_wdata = 32'h12345678;
        applyStimulus(5);
        checkOutput("after_timeout_done", 32'(n_d_done), 32'd2);

        $display("[TB] spurious acknowledge");
        n_i_done = 0; n_d_done = 0;
        force_spur = 1;
        applyStimulus(3);
        checkOutput("spurious_flag", 32'(spurious_ack), 32'd1);
        checkOutput("spurious_no_done", 32'(n_i_done + n_d_done), 32'd0);

        $display("[TB] reset during data access");
        noack_all = 1;
        want_d = 1; want_d_we = 1'b1; want_d_addr = 32'h10010080; want_d_wdata = 32'hA5A5A5A5;
        applyStimulus(4);
        checkOutput("pre_reset_mem_req", 32'(mem_req), 32'd1);
        doReset();
        noack_all = 0;
        applyStimulus(2);
        checkOutput("post_reset_idle", 32'(mem_req), 32'd0);

        $display("[TB] randomized traffic");
        auto_i = 1; auto_d = 1; i_rate = 40; d_rate = 40;
        lat_lo = 0; lat_hi = 3; rand_noack = 1; spur_rate = 3;
        applyStimulus(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction fetch path (I) and the memory-stage data path (D).
- Grants one access at a time and latches address and write data on grant.
- Holds the memory handshake until acknowledge, then returns a done pulse to the owning requester.
- Drives stall signals to the hazard unit, with a starvation guard and a timeout watchdog.

Parameters:
- MAX_D_STREAK, 4, maximum consecutive D grants while I is pending before I is forced through (1..15).
- TIMEOUT, 255, maximum cycles in a busy state before the access is aborted (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch requests an instruction word.
- i_addr  in  32  fetch address.
- i_rdata  out  32  instruction data, valid when i_done.
- i_done  out  1  one-cycle completion pulse for I.
- d_req  in  1  memory stage requests an access.
- d_we  in  1  D write enable.
- d_byte  in  1  D byte access (sb/lb).
- d_addr  in  32  D address.
- d_wdata  in  32  D write data.
- d_rdata  out  32  D read data, valid when d_done.
- d_done  out  1  one-cycle completion pulse for D.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  latched write enable.
- mem_byte  out  1  latched byte flag.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle access completion.
- stall_i  out  1  i_req & ~i_done, to the hazard unit (drives StallF).
- stall_d  out  1  d_req & ~d_done, to the hazard unit.
- bus_error  out  1  sticky: a timeout has occurred.
- spurious_ack  out  1  sticky: mem_ack was seen while idle.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, mem_req/mem_we/mem_byte 0, mem_addr/mem_wdata 0, streak and timeout counters 0, bus_error/spurious_ack 0.
- Reset mid-access: state goes to IDLE immediately, mem_req deasserts asynchronously, and no done pulse is issued.
- States:
  - IDLE: no access in flight.
  - BUSY_I: an instruction access is outstanding.
  - BUSY_D: a data access is outstanding.
- IDLE arbitration, evaluated each cycle:
  - D only: go to BUSY_D.
  - I only: go to BUSY_I.
  - Both present: D wins unless streak == MAX_D_STREAK, in which case I wins.
  - None: stay in IDLE.
- Grant latching: on the grant edge, latch addr/we/byte/wdata from the winner. I grants force we=0, byte=0, wdata=0.
- mem_req = (state != IDLE). Outputs are stable for the whole busy period.
- Completion: in BUSY_x with mem_ack=1:
  - x_done=1 combinationally in the same cycle.
  - x_rdata = mem_rdata passthrough; it is 0 when not done.
  - Next state is IDLE.
- Minimum latency is 2 cycles per access (grant cycle plus ack cycle); the next arbitration happens in the following cycle.
- Requester contract: hold req until done. A new request may be presented in the cycle after done. If req drops while owned, the access still completes and the done pulse is ignored.
- Streak counter (4-bit):
  - Increments on a D grant while i_req=1.
  - Clears on any I grant, or when i_req=0 in IDLE.
  - Saturates at MAX_D_STREAK.
- Timeout counter:
  - Clears on entry to a busy state and increments each busy cycle without ack.
  - When it reaches TIMEOUT: x_done=1, x_rdata=0, bus_error is set, state goes to IDLE, and mem_req drops next cycle.
  - If ack arrives in the same cycle as the timeout, the ack wins and bus_error is not set.
- mem_ack while IDLE: ignored, and spurious_ack is set.
- Sticky flags clear only on reset.
- Only one done pulse can occur per cycle; i_done and d_done are never asserted together.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_BUSY_I=2'd1, ST_BUSY_D=2'd2.
  - Owner ids OWN_I/OWN_D.
  - Counter widths.
- Sub-module mem_arb_watchdog: the timeout counter with start/clear/expire ports. The arbiter FSM stays in the top module.

Test Plan:
- Reset, then i_req=1 with i_addr=0x00400000 and memory acking 1 cycle after mem_req -> mem_addr=0x00400000, mem_we=0, i_done pulse with i_rdata=mem_rdata=0x2008000A, stall_i high until the done cycle.
- i_req and d_req in the same cycle (d_we=1, d_addr=0x10010004, d_wdata=0xDEADBEEF) -> D granted first with mem_we=1 and the latched data; I granted next; exactly one done pulse per access.
- D requests back-to-back continuously with I held pending and MAX_D_STREAK=4 -> grant order D,D,D,D,I,D…; the streak clears after the I grant.
- Memory never acks with TIMEOUT=8 -> done pulse 8 busy cycles after grant with rdata=0, bus_error=1, mem_req low the next cycle; the following access completes normally.
- reset_n pulsed low mid BUSY_D -> mem_req low immediately, no d_done, IDLE after release, sticky flags cleared.
- mem_ack pulsed while IDLE -> spurious_ack=1, no done pulse, state stays IDLE.
